// File: rtl/corelet_seq.sv
// Instruction sequencer for the corelet: turns a start pulse plus job descriptor
// into the per-cycle 37-bit inst stream for one weight-stationary or output-stationary job.
module corelet_seq #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              os_mode_cfg,
  input  logic              relu_cfg,
  input  logic              acc_cfg,
  input  logic [len_bw-1:0] n_vec,
  input  logic              ofifo_o_valid,
  output logic [36:0]       inst,
  output logic              busy,
  output logic              done
);

  localparam int SPAN_BW = $clog2(row + col + 1);
  localparam int CW      = (len_bw > SPAN_BW) ? len_bw : SPAN_BW;

  localparam logic [CW-1:0] COL_LAST    = CW'(col - 1);
  localparam logic [CW-1:0] ROW_LAST    = CW'(row - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(row + col - 1);

  typedef enum logic [3:0] {
    IDLE, WFILL, WLOAD, WWAIT, XFILL, EXEC, DRAIN,
    OFILL, OEXEC, OSETTLE, OFLUSH, DONE
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, rd_cnt, n_last;
  logic [len_bw-1:0] n_lat;
  logic              os_lat, relu_lat, acc_lat;
  logic              ofifo_rd;

  // n_lat is never 0 outside IDLE/DONE, so n_last does not underflow where it is used
  assign n_last   = CW'(n_lat) - CW'(1);
  assign ofifo_rd = (state == DRAIN) && ofifo_o_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_cnt   <= '0;
      n_lat    <= '0;
      os_lat   <= 1'b0;
      relu_lat <= 1'b0;
      acc_lat  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= (state_nx != state || state_nx == IDLE) ? '0 : cnt + CW'(1);
      rd_cnt <= (state != DRAIN) ? '0 : rd_cnt + CW'(ofifo_rd);
      if (state == IDLE && start) begin
        os_lat   <= os_mode_cfg;
        relu_lat <= relu_cfg;
        acc_lat  <= acc_cfg;
        n_lat    <= n_vec;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (n_vec == '0) ? DONE : (os_mode_cfg ? OFILL : WFILL);
      WFILL:   if (cnt == COL_LAST)    state_nx = WLOAD;
      WLOAD:   if (cnt == COL_LAST)    state_nx = WWAIT;
      WWAIT:   if (cnt == SETTLE_LAST) state_nx = XFILL;
      XFILL:   if (cnt == n_last)      state_nx = EXEC;
      EXEC:    if (cnt == n_last)      state_nx = DRAIN;
      DRAIN:   if (ofifo_rd && rd_cnt == n_last) state_nx = DONE;
      OFILL:   if (cnt == n_last)      state_nx = OEXEC;
      OEXEC:   if (cnt == n_last)      state_nx = OSETTLE;
      OSETTLE: if (cnt == SETTLE_LAST) state_nx = OFLUSH;
      OFLUSH:  if (cnt == ROW_LAST)    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    inst = '0;
    busy = (state != IDLE);
    done = (state == DONE);
    if (state != IDLE) inst[35] = os_lat;
    unique case (state)
      WFILL, XFILL: inst[2] = 1'b1;
      WLOAD: begin
        inst[3] = 1'b1;
        inst[0] = 1'b1;
      end
      EXEC: begin
        inst[3] = 1'b1;
        inst[1] = 1'b1;
      end
      DRAIN: begin
        inst[6]  = ofifo_rd;
        inst[34] = relu_lat;
        inst[33] = acc_lat & ofifo_rd;
      end
      OFILL: begin
        inst[2] = 1'b1;
        inst[5] = 1'b1;
      end
      OEXEC: begin
        inst[3] = 1'b1;
        inst[4] = 1'b1;
        inst[1] = 1'b1;
      end
      OFLUSH:  inst[36] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(inst[0] && inst[1]));
      assert (!(inst[36] && !inst[35]));
      assert (!(inst[2] && inst[3]));
    end
  end

endmodule

// File: tb/tb_corelet_seq.sv
// Scoreboard bench for corelet_seq: the driver pushes the expected inst/busy/done
// for each cycle it drives, and a negedge monitor pops and compares.
module tb_corelet_seq;

  logic        clk = 1'b0;
  logic        reset, start, os_mode_cfg, relu_cfg, acc_cfg, ofifo_o_valid;
  logic [5:0]  n_vec;
  logic [36:0] inst;
  logic        busy, done;

  corelet_seq #(.row(8), .col(8), .len_bw(6)) dut (
    .clk(clk), .reset(reset), .start(start), .os_mode_cfg(os_mode_cfg),
    .relu_cfg(relu_cfg), .acc_cfg(acc_cfg), .n_vec(n_vec),
    .ofifo_o_valid(ofifo_o_valid), .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [36:0] LOAD  = 37'b1 << 0;
  localparam logic [36:0] EXE   = 37'b1 << 1;
  localparam logic [36:0] L0WR  = 37'b1 << 2;
  localparam logic [36:0] L0RD  = 37'b1 << 3;
  localparam logic [36:0] IFRD  = 37'b1 << 4;
  localparam logic [36:0] IFWR  = 37'b1 << 5;
  localparam logic [36:0] OFRD  = 37'b1 << 6;
  localparam logic [36:0] ACC   = 37'b1 << 33;
  localparam logic [36:0] RELU  = 37'b1 << 34;
  localparam logic [36:0] OSB   = 37'b1 << 35;
  localparam logic [36:0] FLUSH = 37'b1 << 36;

  typedef struct {
    logic [36:0] inst;
    logic        busy;
    logic        done;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [36:0] i, input logic b, input logic d, input string tag);
    exp_t e;
    e.inst = i; e.busy = b; e.done = d; e.tag = tag;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (inst !== e.inst || busy !== e.busy || done !== e.done) begin
        failures++;
        $display("FAIL %s: got inst=%h busy=%b done=%b, required inst=%h busy=%b done=%b",
                 e.tag, inst, busy, done, e.inst, e.busy, e.done);
      end
    end
  end

  // WS job; toggle = valid alternates 1,0,.. from drain start; extra_start/reset_at = cycle or 0
  task automatic run_ws(input string name, input int n, input logic relu, input logic acc,
                        input logic toggle, input int extra_start, input int reset_at);
    int          d0, dn, last;
    logic        v;
    logic [36:0] ei;
    d0   = 33 + 2 * n;
    dn   = toggle ? d0 + 2 * n - 1 : d0 + n;
    last = (reset_at > 0) ? reset_at + 3 : dn + 1;
    step();
    start = 1'b1; os_mode_cfg = 1'b0; relu_cfg = relu; acc_cfg = acc;
    n_vec = n[5:0]; ofifo_o_valid = 1'b1;
    push('0, 1'b0, 1'b0, $sformatf("%s c0", name));
    for (int c = 1; c <= last; c++) begin
      step();
      start       = (c == extra_start);
      reset       = (c == reset_at);
      os_mode_cfg = 1'b1; relu_cfg = ~relu; acc_cfg = ~acc; n_vec = 6'd63;
      v = (toggle && c >= d0) ? ((c - d0) % 2 == 0) : 1'b1;
      ofifo_o_valid = v;
      if (reset_at > 0 && c > reset_at) push('0, 1'b0, 1'b0, $sformatf("%s c%0d", name, c));
      else if (c == dn)  push('0, 1'b1, 1'b1, $sformatf("%s c%0d", name, c));
      else if (c > dn)   push('0, 1'b0, 1'b0, $sformatf("%s c%0d", name, c));
      else begin
        if (c <= 8)               ei = L0WR;
        else if (c <= 16)         ei = L0RD | LOAD;
        else if (c <= 32)         ei = '0;
        else if (c <= 32 + n)     ei = L0WR;
        else if (c <= 32 + 2 * n) ei = L0RD | EXE;
        else ei = (relu ? RELU : '0) | (v ? OFRD : '0) | ((acc && v) ? ACC : '0);
        push(ei, 1'b1, 1'b0, $sformatf("%s c%0d", name, c));
      end
    end
    start = 1'b0; reset = 1'b0;
  endtask

  task automatic run_os(input string name, input int n);
    logic [36:0] ei;
    int          dn;
    dn = 2 * n + 25;
    step();
    start = 1'b1; os_mode_cfg = 1'b1; relu_cfg = 1'b1; acc_cfg = 1'b1;
    n_vec = n[5:0]; ofifo_o_valid = 1'b1;
    push('0, 1'b0, 1'b0, $sformatf("%s c0", name));
    for (int c = 1; c <= dn + 1; c++) begin
      step();
      start = 1'b0; os_mode_cfg = 1'b0; n_vec = 6'd1;
      if (c <= n)               ei = OSB | L0WR | IFWR;
      else if (c <= 2 * n)      ei = OSB | L0RD | IFRD | EXE;
      else if (c <= 2 * n + 16) ei = OSB;
      else if (c <= 2 * n + 24) ei = OSB | FLUSH;
      else if (c == dn)         ei = OSB;
      else                      ei = '0;
      push(ei, c <= dn, c == dn, $sformatf("%s c%0d", name, c));
    end
  endtask

  task automatic run_zero(input string name, input logic os);
    step();
    start = 1'b1; os_mode_cfg = os; n_vec = '0;
    push('0, 1'b0, 1'b0, $sformatf("%s c0", name));
    step();
    start = 1'b0;
    push(os ? OSB : '0, 1'b1, 1'b1, $sformatf("%s c1", name));
    for (int c = 2; c <= 3; c++) begin
      step();
      push('0, 1'b0, 1'b0, $sformatf("%s c%0d", name, c));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; os_mode_cfg = 1'b0; relu_cfg = 1'b0;
    acc_cfg = 1'b0; n_vec = '0; ofifo_o_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      push('0, 1'b0, 1'b0, $sformatf("reset c%0d", i));
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      push('0, 1'b0, 1'b0, $sformatf("idle c%0d", i));
    end

    run_ws("ws",     4, 1'b0, 1'b0, 1'b0, 0, 0);
    run_ws("bp",     4, 1'b1, 1'b1, 1'b1, 0, 0);
    run_os("os",     3);
    run_ws("ignore", 4, 1'b0, 1'b0, 1'b0, 38, 0);
    run_ws("abort",  4, 1'b0, 1'b0, 1'b0, 0, 38);
    run_ws("after",  4, 1'b1, 1'b0, 1'b0, 0, 0);
    run_zero("zero_ws", 1'b0);
    run_zero("zero_os", 1'b1);

    for (int i = 0; i < 4 && q.size() > 0; i++) step();
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
